// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction fetch stage: PC, SRAM req/ack fetch, IF/ID register.
// Optional IF_ADDR_ALIGN_CHECK_EN: misaligned fetch PC raises id_adel instead of fetching.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] redirect_pc_i,
   output logic        inst_req_o,
   output logic [31:0] inst_addr_o,
   input  logic        inst_ack_i,
   input  logic [31:0] inst_rdata_i,
   output logic        id_valid_o,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_inst_o,
   output logic [5:0]  id_opcode_o,
   output logic        id_adel_o
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_KILL  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] target_q, target_d;
   logic [31:0] hold_pc_q, hold_pc_d;
   logic [31:0] hold_inst_q, hold_inst_d;
   logic        hold_full_q, hold_full_d;
   logic        id_valid_q, id_valid_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_inst_q, id_inst_d;
   logic        id_adel_q, id_adel_d;
   logic        misalign;
   logic        req;
   logic        ack;

`ifdef IF_ADDR_ALIGN_CHECK_EN
   assign misalign = (pc_q[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   // Acks that arrive while no request is driven (including during reset) are ignored.
   assign req = !rst_i && (((state_q == S_FETCH) && !misalign) || (state_q == S_KILL));
   assign ack = inst_ack_i && req;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      target_d    = target_q;
      hold_pc_d   = hold_pc_q;
      hold_inst_d = hold_inst_q;
      hold_full_d = hold_full_q;
      id_valid_d  = id_valid_q;
      id_pc_d     = id_pc_q;
      id_inst_d   = id_inst_q;
      id_adel_d   = id_adel_q;

      if (flush_i) begin
         id_valid_d  = 1'b0;
         id_adel_d   = 1'b0;
         hold_full_d = 1'b0;
         // An unanswered request must drain before the redirect target is fetched.
         if (req && !ack) begin
            target_d = redirect_pc_i;
            state_d  = S_KILL;
         end else begin
            pc_d    = redirect_pc_i;
            state_d = S_FETCH;
         end
      end else begin
         case (state_q)
            S_FETCH: begin
               if (misalign) begin
                  if (!stall_i) begin
                     id_valid_d  = 1'b1;
                     id_adel_d   = 1'b1;
                     id_pc_d     = pc_q;
                     id_inst_d   = 32'h0;
                     hold_full_d = 1'b0;
                     state_d     = S_HOLD;
                  end
               end else if (ack) begin
                  pc_d = pc_q + 32'd4;
                  if (stall_i) begin
                     hold_pc_d   = pc_q;
                     hold_inst_d = inst_rdata_i;
                     hold_full_d = 1'b1;
                     state_d     = S_HOLD;
                  end else begin
                     id_valid_d = 1'b1;
                     id_adel_d  = 1'b0;
                     id_pc_d    = pc_q;
                     id_inst_d  = inst_rdata_i;
                  end
               end else if (!stall_i) begin
                  id_valid_d = 1'b0;
               end
            end
            S_HOLD: begin
               // An empty buffer here means an address-error park that only flush leaves.
               if (!stall_i && hold_full_q) begin
                  id_valid_d  = 1'b1;
                  id_adel_d   = 1'b0;
                  id_pc_d     = hold_pc_q;
                  id_inst_d   = hold_inst_q;
                  hold_full_d = 1'b0;
                  state_d     = S_FETCH;
               end
            end
            S_KILL: begin
               if (ack) begin
                  pc_d    = target_q;
                  state_d = S_FETCH;
               end
            end
            default: state_d = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_FETCH;
         pc_q        <= RESET_PC;
         target_q    <= 32'h0;
         hold_pc_q   <= 32'h0;
         hold_inst_q <= 32'h0;
         hold_full_q <= 1'b0;
         id_valid_q  <= 1'b0;
         id_pc_q     <= 32'h0;
         id_inst_q   <= 32'h0;
         id_adel_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         target_q    <= target_d;
         hold_pc_q   <= hold_pc_d;
         hold_inst_q <= hold_inst_d;
         hold_full_q <= hold_full_d;
         id_valid_q  <= id_valid_d;
         id_pc_q     <= id_pc_d;
         id_inst_q   <= id_inst_d;
         id_adel_q   <= id_adel_d;
      end
   end

   assign inst_req_o  = req;
   assign inst_addr_o = pc_q;
   assign id_valid_o  = id_valid_q;
   assign id_pc_o     = id_pc_q;
   assign id_inst_o   = id_inst_q;
   assign id_opcode_o = id_inst_q[31:26];
   assign id_adel_o   = id_adel_q;

endmodule
